// File: rtl/rtp_engine_pkg.sv
// Shared types for the RTP transmit scheduler.
//   state_e     : scheduler FSM states
//   *_W         : descriptor field widths
//   state_busy  : state-to-busy status mapping
package rtp_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_EOP  = 2'd3
  } state_e;

  localparam int SEQ_W  = 32;
  localparam int TS_W   = 32;
  localparam int LINE_W = 16;
  localparam int FCNT_W = 32;

  function automatic logic state_busy(input state_e s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/rtp_engine_tx_sched.sv
// RTP transmit scheduler: sequences header descriptors and payload beats
// for one packet per video line, advancing seq/line/timestamp per packet.
// Ports:
//   aclk, aresetn                  clock, async active-low reset
//   start_transfer, stop_transfer  regmap session control levels
//   seq_number_init                extended seq loaded at session start
//   hdr_valid/hdr_ready            header-descriptor handshake
//   hdr_seq/timestamp/line/marker  descriptor fields
//   data_en, data_beat, data_last  payload beat gating and end-of-packet
//   busy, frame_cnt                status
module rtp_engine_tx_sched
  import rtp_engine_pkg::*;
#(
  parameter int PKT_BEATS      = 64,
  parameter int PKTS_PER_FRAME = 1080,
  parameter int TS_INCR        = 1500
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start_transfer,
  input  logic              stop_transfer,
  input  logic [SEQ_W-1:0]  seq_number_init,
  output logic              hdr_valid,
  input  logic              hdr_ready,
  output logic [SEQ_W-1:0]  hdr_seq,
  output logic [TS_W-1:0]   hdr_timestamp,
  output logic [LINE_W-1:0] hdr_line,
  output logic              hdr_marker,
  output logic              data_en,
  input  logic              data_beat,
  output logic              data_last,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int BW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam logic [BW-1:0]     LAST_BEAT = BW'(PKT_BEATS - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(PKTS_PER_FRAME - 1);
  localparam logic [TS_W-1:0]   TS_STEP   = TS_W'(TS_INCR);

  state_e              state_q, state_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic [TS_W-1:0]     ts_q, ts_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [FCNT_W-1:0]   frame_q, frame_d;
  logic                stop_pend_q, stop_pend_d;
  logic                start_q, start_d;
  // Set once start_transfer has been seen low after reset, so a level
  // already high at release is not mistaken for an edge.
  logic                armed_q, armed_d;
  logic                start_edge;

  assign start_edge = start_transfer & ~start_q & armed_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      seq_q       <= '0;
      ts_q        <= '0;
      line_q      <= '0;
      beat_q      <= '0;
      frame_q     <= '0;
      stop_pend_q <= 1'b0;
      start_q     <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      ts_q        <= ts_d;
      line_q      <= line_d;
      beat_q      <= beat_d;
      frame_q     <= frame_d;
      stop_pend_q <= stop_pend_d;
      start_q     <= start_d;
      armed_q     <= armed_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    ts_d        = ts_q;
    line_d      = line_q;
    beat_d      = beat_q;
    frame_d     = frame_q;
    stop_pend_d = stop_pend_q;
    start_d     = start_transfer;
    armed_d     = armed_q | ~start_transfer;

    if (state_q != ST_IDLE && stop_transfer) stop_pend_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (start_edge && !stop_transfer) begin
          seq_d   = seq_number_init;
          line_d  = '0;
          ts_d    = '0;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (hdr_ready) begin
          beat_d  = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (data_beat) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = ST_EOP;
        end
      end
      ST_EOP: begin
        seq_d = seq_q + 1'b1;
        if (line_q == LAST_LINE) begin
          line_d  = '0;
          ts_d    = ts_q + TS_STEP;
          frame_d = frame_q + 1'b1;
        end else begin
          line_d = line_q + 1'b1;
        end
        // Stop is only honoured here, so packets are never cut short.
        if (stop_pend_q || stop_transfer) begin
          stop_pend_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_HDR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign hdr_valid     = (state_q == ST_HDR);
  assign hdr_seq       = seq_q;
  assign hdr_timestamp = ts_q;
  assign hdr_line      = line_q;
  assign hdr_marker    = (line_q == LAST_LINE);
  assign data_en       = (state_q == ST_DATA);
  assign data_last     = (state_q == ST_DATA) && (beat_q == LAST_BEAT);
  assign busy          = state_busy(state_q);
  assign frame_cnt     = frame_q;

endmodule

// File: tb/tb_rtp_engine_tx_sched.sv
// Directed self-checking bench for rtp_engine_tx_sched with
// PKT_BEATS=4, PKTS_PER_FRAME=3, TS_INCR=100.
module tb_rtp_engine_tx_sched;

  logic        aclk;
  logic        aresetn;
  logic        start_transfer;
  logic        stop_transfer;
  logic [31:0] seq_number_init;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [31:0] hdr_seq;
  logic [31:0] hdr_timestamp;
  logic [15:0] hdr_line;
  logic        hdr_marker;
  logic        data_en;
  logic        data_beat;
  logic        data_last;
  logic        busy;
  logic [31:0] frame_cnt;

  int unsigned n_total;
  int unsigned n_pass;

  rtp_engine_tx_sched #(
    .PKT_BEATS     (4),
    .PKTS_PER_FRAME(3),
    .TS_INCR       (100)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .start_transfer (start_transfer),
    .stop_transfer  (stop_transfer),
    .seq_number_init(seq_number_init),
    .hdr_valid      (hdr_valid),
    .hdr_ready      (hdr_ready),
    .hdr_seq        (hdr_seq),
    .hdr_timestamp  (hdr_timestamp),
    .hdr_line       (hdr_line),
    .hdr_marker     (hdr_marker),
    .data_en        (data_en),
    .data_beat      (data_beat),
    .data_last      (data_last),
    .busy           (busy),
    .frame_cnt      (frame_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // Entered with the DUT in HDR, hdr_ready=1 and data_beat=1 held.
  // Returns one cycle after EOP.
  task automatic do_packet(input logic [31:0] s, input logic [15:0] l,
                           input logic [31:0] t, input logic m);
    chk1 ("pkt_hdr_valid", hdr_valid, 1'b1);
    chk32("pkt_hdr_seq", hdr_seq, s);
    chk32("pkt_hdr_line", {16'b0, hdr_line}, {16'b0, l});
    chk32("pkt_hdr_ts", hdr_timestamp, t);
    chk1 ("pkt_hdr_marker", hdr_marker, m);
    tick();
    for (int b = 0; b < 4; b++) begin
      chk1("pkt_data_en", data_en, 1'b1);
      chk1("pkt_data_last", data_last, (b == 3));
      tick();
    end
    chk1("eop_hdr_valid", hdr_valid, 1'b0);
    chk1("eop_data_en", data_en, 1'b0);
    chk1("eop_busy", busy, 1'b1);
    tick();
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    aresetn = 1'b0;
    start_transfer = 1'b0;
    stop_transfer  = 1'b0;
    seq_number_init = '0;
    hdr_ready = 1'b0;
    data_beat = 1'b0;

    // Reset state
    tick(); tick();
    chk1 ("rst_busy", busy, 1'b0);
    chk1 ("rst_hdr_valid", hdr_valid, 1'b0);
    chk1 ("rst_data_en", data_en, 1'b0);
    chk1 ("rst_data_last", data_last, 1'b0);
    chk32("rst_frame_cnt", frame_cnt, 32'd0);
    aresetn = 1'b1;
    tick();

    // Full frame plus one packet, continuous handshake
    seq_number_init = 32'h10;
    hdr_ready = 1'b1;
    data_beat = 1'b1;
    start_transfer = 1'b1;
    tick();
    chk1("start_busy", busy, 1'b1);
    do_packet(32'h10, 16'd0, 32'd0, 1'b0);
    do_packet(32'h11, 16'd1, 32'd0, 1'b0);
    do_packet(32'h12, 16'd2, 32'd0, 1'b1);
    chk32("frame_cnt_1", frame_cnt, 32'd1);
    stop_transfer = 1'b1;
    do_packet(32'h13, 16'd0, 32'd100, 1'b0);
    chk1("stop1_busy", busy, 1'b0);
    stop_transfer = 1'b0;
    tick();
    chk1("stop1_no_hdr", hdr_valid, 1'b0);

    // Sequence number wrap
    start_transfer = 1'b0;
    tick();
    seq_number_init = 32'hFFFF_FFFE;
    start_transfer = 1'b1;
    tick();
    do_packet(32'hFFFF_FFFE, 16'd0, 32'd0, 1'b0);
    do_packet(32'hFFFF_FFFF, 16'd1, 32'd0, 1'b0);
    do_packet(32'h0000_0000, 16'd2, 32'd0, 1'b1);
    chk32("frame_cnt_2", frame_cnt, 32'd2);
    stop_transfer = 1'b1;
    do_packet(32'h0000_0001, 16'd0, 32'd100, 1'b0);
    stop_transfer = 1'b0;
    chk1("stop2_busy", busy, 1'b0);

    // Stop pulse during beat 1 of packet 0
    start_transfer = 1'b0;
    tick();
    seq_number_init = 32'h20;
    start_transfer = 1'b1;
    tick();
    chk32("s3_hdr_seq", hdr_seq, 32'h20);
    tick();                  // DATA, beat 0 offered
    tick();                  // beat 1 offered next
    stop_transfer = 1'b1;
    tick();
    stop_transfer = 1'b0;
    chk1("s3_b2_data_en", data_en, 1'b1);
    chk1("s3_b2_last", data_last, 1'b0);
    tick();
    chk1("s3_b3_last", data_last, 1'b1);
    tick();
    chk1("s3_eop_busy", busy, 1'b1);
    chk1("s3_eop_data_en", data_en, 1'b0);
    tick();
    chk1("s3_idle_busy", busy, 1'b0);
    tick(); tick();
    chk1("s3_no_hdr", hdr_valid, 1'b0);

    // hdr_ready stall with beats offered in HDR
    start_transfer = 1'b0;
    tick();
    seq_number_init = 32'h30;
    hdr_ready = 1'b0;
    data_beat = 1'b1;
    start_transfer = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk1 ("stall_hdr_valid", hdr_valid, 1'b1);
      chk32("stall_hdr_seq", hdr_seq, 32'h30);
      chk32("stall_hdr_line", {16'b0, hdr_line}, 32'd0);
      tick();
    end
    hdr_ready = 1'b1;
    data_beat = 1'b0;
    tick();
    chk1("stall_data_en", data_en, 1'b1);
    chk1("stall_b0_last", data_last, 1'b0);
    data_beat = 1'b1;
    tick(); tick(); tick();
    chk1("stall_b3_last", data_last, 1'b1);
    stop_transfer = 1'b1;
    tick();
    tick();
    stop_transfer = 1'b0;
    chk1("stall_end_busy", busy, 1'b0);

    // Start and stop rising together are ignored
    start_transfer = 1'b0;
    tick();
    seq_number_init = 32'h40;
    start_transfer = 1'b1;
    stop_transfer  = 1'b1;
    tick();
    chk1("both_busy_a", busy, 1'b0);
    tick();
    chk1("both_busy_b", busy, 1'b0);
    start_transfer = 1'b0;
    stop_transfer  = 1'b0;
    tick();
    start_transfer = 1'b1;
    tick();
    chk1("retoggle_busy", busy, 1'b1);
    stop_transfer = 1'b1;
    do_packet(32'h40, 16'd0, 32'd0, 1'b0);
    stop_transfer = 1'b0;
    chk1("retoggle_end_busy", busy, 1'b0);

    // Reset mid-DATA, then start held high across release
    start_transfer = 1'b0;
    tick();
    seq_number_init = 32'h50;
    start_transfer = 1'b1;
    tick();
    tick();
    tick();
    chk1("mid_data_en", data_en, 1'b1);
    aresetn = 1'b0;
    tick();
    chk1 ("mrst_hdr_valid", hdr_valid, 1'b0);
    chk1 ("mrst_data_en", data_en, 1'b0);
    chk1 ("mrst_data_last", data_last, 1'b0);
    chk1 ("mrst_busy", busy, 1'b0);
    chk32("mrst_frame_cnt", frame_cnt, 32'd0);
    chk32("mrst_hdr_seq", hdr_seq, 32'd0);
    aresetn = 1'b1;
    tick(); tick();
    chk1("held_start_busy", busy, 1'b0);
    start_transfer = 1'b0;
    tick();
    chk1("low_start_busy", busy, 1'b0);
    start_transfer = 1'b1;
    tick();
    chk1 ("restart_busy", busy, 1'b1);
    chk32("restart_hdr_seq", hdr_seq, 32'h50);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rtp_engine_tx_sched.md
RTP_ENGINE_TX_SCHED -- requirements
Module: rtp_engine_tx_sched

Interface
REQ-001 SHALL have parameter PKT_BEATS, default 64, data beats per RTP packet (>=2).
REQ-002 SHALL have parameter PKTS_PER_FRAME, default 1080, packets (lines) per video frame (>=1).
REQ-003 SHALL have parameter TS_INCR, default 1500, RTP timestamp increment per frame.
REQ-004 SHALL have port aclk, input, 1, the only clock.
REQ-005 SHALL have port aresetn, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port start_transfer, input, 1, level from regmap; rising edge starts a session.
REQ-007 SHALL have port stop_transfer, input, 1, level from regmap; high requests a session stop.
REQ-008 SHALL have port seq_number_init, input, 32, extended sequence number loaded at session start.
REQ-009 SHALL have ports hdr_valid (output, 1) and hdr_ready (input, 1), the header-descriptor handshake.
REQ-010 SHALL have descriptor outputs: hdr_seq (32), hdr_timestamp (32), hdr_line (16) and hdr_marker (1).
REQ-011 SHALL have port data_en, output, 1, permits payload beats.
REQ-012 SHALL have port data_beat, input, 1, pulse for an accepted payload beat (tvalid&tready).
REQ-013 SHALL have port data_last, output, 1, marks the final beat of a packet.
REQ-014 SHALL have ports busy (output, 1) and frame_cnt (output, 32), the status outputs.

Function
REQ-015 SHALL implement states IDLE, HDR, DATA, EOP.
REQ-016 SHALL detect a start as start_transfer high with its registered copy low.
REQ-017 In IDLE, a start with stop_transfer low SHALL load seq=seq_number_init, line=0, timestamp=0, then go to HDR.
REQ-018 In IDLE, a start with stop_transfer high SHALL be ignored, and the block SHALL stay in IDLE.
REQ-019 In HDR, hdr_valid SHALL be 1 and the descriptor fields SHALL be stable until hdr_ready.
REQ-020 In HDR, hdr_valid&hdr_ready SHALL move the block to DATA and clear beat_cnt.
REQ-021 hdr_marker SHALL be 1 exactly when line==PKTS_PER_FRAME-1.
REQ-022 In DATA, data_en SHALL be 1, and each data_beat SHALL increment beat_cnt.
REQ-023 data_last SHALL equal (state==DATA && beat_cnt==PKT_BEATS-1), combinationally.
REQ-024 data_beat while data_last is high SHALL move the block to EOP.
REQ-025 data_beat outside DATA SHALL be ignored.
REQ-026 EOP SHALL last exactly 1 cycle.
REQ-027 In EOP, seq SHALL increment by 1, mod 2^32; 0xFFFFFFFF SHALL wrap to 0.
REQ-028 In EOP, line SHALL increment by 1.
REQ-029 In EOP with line==PKTS_PER_FRAME-1, line SHALL become 0, timestamp SHALL increase by TS_INCR (mod 2^32) and frame_cnt SHALL increment.
REQ-030 A stop_transfer high sample outside IDLE SHALL set stop_pending.
REQ-031 From EOP, the block SHALL go to IDLE and clear stop_pending if stop_pending is set or stop_transfer is high; otherwise it SHALL go to HDR.
REQ-032 A stop SHALL never truncate a packet or withdraw a hdr_valid.
REQ-033 A start edge outside IDLE SHALL be ignored.
REQ-034 busy SHALL be 1 in every state except IDLE.
REQ-035 Latency SHALL be: start edge to hdr_valid 1 cycle; final data_beat to next hdr_valid 2 cycles.

Reset
REQ-036 aresetn low SHALL force IDLE and zero seq, timestamp, line, beat_cnt, frame_cnt, stop_pending and the start edge register.
REQ-037 During reset, hdr_valid, data_en, data_last and busy SHALL be 0.
REQ-038 Reset asserted mid-packet SHALL abort immediately; there SHALL be no recovery of the partial packet.
REQ-039 After release, a start_transfer already high SHALL NOT count as an edge until it has been seen low.

Structure
REQ-040 State enum, descriptor field widths and the state-to-busy mapping SHALL live in rtp_engine_pkg.
REQ-041 There SHALL be no sub-module; edge detection and counters SHALL be inline.

Verification (PKT_BEATS=4, PKTS_PER_FRAME=3, TS_INCR=100)
REQ-042 Start with init 0x00000010, hdr_ready held 1, continuous beats -> packets carry seq 0x10,0x11,0x12; lines 0,1,2; marker only on line 2; next packet line 0 with timestamp 100; frame_cnt=1.
REQ-043 Init 0xFFFFFFFE, 3 packets -> hdr_seq 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-044 Stop pulse during beat 1 of packet 0 -> remaining 3 beats complete with data_last on beat 3; busy goes 0 one cycle after EOP; no further hdr_valid.
REQ-045 hdr_ready held 0 for 5 cycles -> hdr_valid and descriptor stable for all 5; beats offered while in HDR ignored (beat_cnt stays 0).
REQ-046 start_transfer and stop_transfer rise together in IDLE -> stays IDLE; start re-toggled later with stop low -> session starts.
REQ-047 aresetn low mid-DATA -> all outputs 0 next edge; after release with start held high -> no session until start goes low and then high.
